// File: rtl/mode_select_ctrl.sv
// Pushbutton front end for the 4-mode clock divider: sync, debounce, press detect, mode step.
// Define MODE_WRAP_EN to make mode wrap at 3/0; otherwise it saturates.
module mode_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [1:0]  RESET_MODE      = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic       up_level,
  output logic       dn_level
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the UP button, bit 1 the DOWN button throughout.
  logic [1:0]           raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           level_q, level_d;
  logic [1:0]           hist_q;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0]           press;
  logic [1:0]           mode_q, mode_d;
  logic                 changed_q, changed_d;

  assign raw = {btn_dn, btn_up};

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Only rising edges of the debounced level count as presses.
  assign press = level_q & ~hist_q;

  always_comb begin
    mode_d = mode_q;
    case (press)
      2'b01: begin
`ifdef MODE_WRAP_EN
        mode_d = mode_q + 2'd1;
`else
        if (mode_q != 2'd3) mode_d = mode_q + 2'd1;
`endif
      end
      2'b10: begin
`ifdef MODE_WRAP_EN
        mode_d = mode_q - 2'd1;
`else
        if (mode_q != 2'd0) mode_d = mode_q - 2'd1;
`endif
      end
      default: mode_d = mode_q;
    endcase
    changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      hist_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= RESET_MODE;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      hist_q    <= level_q;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      changed_q <= changed_d;
    end
  end

  assign mode         = mode_q;
  assign mode_changed = changed_q;
  assign up_level     = level_q[0];
  assign dn_level     = level_q[1];

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Directed bench for mode_select_ctrl (DEBOUNCE_CYCLES=4): a cycle model is compared every
// cycle against two instances (RESET_MODE 0 and 2), plus literal checkpoints.
module tb_mode_select_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_up = 1'b0, a_dn = 1'b0, b_up = 1'b0, b_dn = 1'b0;
  logic [1:0] a_mode, b_mode;
  logic       a_chg, b_chg, a_ul, b_ul, a_dl, b_dl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mode_select_ctrl #(.DEBOUNCE_CYCLES(D), .RESET_MODE(2'd0)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_up(a_up), .btn_dn(a_dn),
    .mode(a_mode), .mode_changed(a_chg), .up_level(a_ul), .dn_level(a_dl)
  );

  mode_select_ctrl #(.DEBOUNCE_CYCLES(D), .RESET_MODE(2'd2)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_up(b_up), .btn_dn(b_dn),
    .mode(b_mode), .mode_changed(b_chg), .up_level(b_ul), .dn_level(b_dl)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state, index [instance][button], button 0 = UP, 1 = DOWN.
  int m_mode[2];
  int m_chg[2];
  int s1[2][2], s2[2][2], lvl[2][2], run[2][2], pend[2][2];
  int reset_mode[2] = '{0, 2};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = reset_mode[i];
      m_chg[i]  = 0;
      for (int b = 0; b < 2; b++) begin
        s1[i][b] = 0; s2[i][b] = 0; lvl[i][b] = 0; run[i][b] = 0; pend[i][b] = 0;
      end
    end
  endtask

  initial begin
    int nm, old;
    int rawv[2][2];
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        rawv = '{'{int'(a_up), int'(a_dn)}, '{int'(b_up), int'(b_dn)}};
        for (int i = 0; i < 2; i++) begin
          // A press seen last cycle moves mode now; simultaneous presses cancel.
          nm = m_mode[i] + pend[i][0] - pend[i][1];
`ifdef MODE_WRAP_EN
          nm = (nm + 4) % 4;
`else
          if (nm > 3) nm = 3;
          if (nm < 0) nm = 0;
`endif
          m_chg[i]  = (nm != m_mode[i]) ? 1 : 0;
          m_mode[i] = nm;
          for (int b = 0; b < 2; b++) begin
            old = lvl[i][b];
            // Level follows the synchronised input once it has disagreed for D edges in a row.
            if (s2[i][b] == lvl[i][b]) run[i][b] = 0;
            else if (run[i][b] == D - 1) begin
              lvl[i][b] = s2[i][b];
              run[i][b] = 0;
            end else run[i][b]++;
            pend[i][b] = (lvl[i][b] == 1 && old == 0) ? 1 : 0;
            s2[i][b] = s1[i][b];
            s1[i][b] = rawv[i][b];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("A.mode", int'(a_mode), m_mode[0]);
      chk("A.mode_changed", int'(a_chg), m_chg[0]);
      chk("A.up_level", int'(a_ul), lvl[0][0]);
      chk("A.dn_level", int'(a_dl), lvl[0][1]);
      chk("B.mode", int'(b_mode), m_mode[1]);
      chk("B.mode_changed", int'(b_chg), m_chg[1]);
      chk("B.up_level", int'(b_ul), lvl[1][0]);
      chk("B.dn_level", int'(b_dl), lvl[1][1]);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: a_up = v;
      1: a_dn = v;
      2: b_up = v;
      default: b_dn = v;
    endcase
  endtask

  task automatic press(input int which);
    @(negedge clk);
    drive(which, 1'b1);
    repeat (8) @(negedge clk);
    drive(which, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset mode", int'(a_mode), 0);
    chk("reset B mode", int'(b_mode), 2);
    chk("reset up_level", int'(a_ul), 0);

    // UP held 20 cycles: level after E6, step at E7, single pulse.
    a_up = 1'b1;
    repeat (6) @(negedge clk);
    chk("E6 up_level", int'(a_ul), 1);
    chk("E6 mode", int'(a_mode), 0);
    @(negedge clk);
    chk("E7 mode", int'(a_mode), 1);
    chk("E7 pulse", int'(a_chg), 1);
    @(negedge clk);
    chk("E8 pulse", int'(a_chg), 0);
    repeat (12) @(negedge clk);
    a_up = 1'b0;
    repeat (10) @(negedge clk);
    chk("held one step", int'(a_mode), 1);

    // Glitches of 3 cycles never pass the debounce.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_up = 1'b1;
      repeat (3) @(negedge clk);
      a_up = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("glitch mode", int'(a_mode), 0);
    chk("glitch level", int'(a_ul), 0);

    // Four presses walk to the top boundary.
    press(0); chk("press1", int'(a_mode), 1);
    press(0); chk("press2", int'(a_mode), 2);
    press(0); chk("press3", int'(a_mode), 3);
    press(0);
`ifdef MODE_WRAP_EN
    chk("press4 wrap", int'(a_mode), 0);
`else
    chk("press4 sat", int'(a_mode), 3);
`endif
    do_reset();
    press(1);
`ifdef MODE_WRAP_EN
    chk("down at 0 wrap", int'(a_mode), 3);
`else
    chk("down at 0 sat", int'(a_mode), 0);
`endif

    // Both buttons on the same edge cancel.
    do_reset();
    @(negedge clk);
    a_up = 1'b1; a_dn = 1'b1;
    repeat (10) @(negedge clk);
    chk("both levels", int'(a_ul) + int'(a_dl), 2);
    a_up = 1'b0; a_dn = 1'b0;
    repeat (10) @(negedge clk);
    chk("both mode", int'(a_mode), 0);

    // Reset mid-debounce, button held through release.
    press(0);
    chk("pre-reset mode", int'(a_mode), 1);
    @(negedge clk);
    a_up = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async mode", int'(a_mode), 0);
    chk("async pulse", int'(a_chg), 0);
    chk("async level", int'(a_ul), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post-rst E6 mode", int'(a_mode), 0);
    @(negedge clk);
    chk("post-rst E7 mode", int'(a_mode), 1);
    chk("post-rst E7 pulse", int'(a_chg), 1);
    a_up = 1'b0;
    repeat (8) @(negedge clk);

    // RESET_MODE=2 instance: DOWN then UP; release edges do nothing.
    press(3);
    chk("B down", int'(b_mode), 1);
    @(negedge clk);
    b_up = 1'b1;
    repeat (10) @(negedge clk);
    chk("B up", int'(b_mode), 2);
    b_up = 1'b0;
    repeat (10) @(negedge clk);
    chk("B release", int'(b_mode), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
